// File: rtl/traffic_light_pkg.sv
// Shared definitions for the four-way signal controller: lamp codes,
// approach directions, controller phases and the per-lamp code helper.
package traffic_light_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  // Lamp code shown on approach 'lamp' while 'active' is being served in phase 'st'.
  function automatic logic [1:0] lamp_code(state_t st, dir_t active, dir_t lamp);
    logic [1:0] code;
    code = RED;
    if (active == lamp) begin
      case (st)
        ST_GREEN:  code = GREEN;
        ST_YELLOW: code = YELLOW;
        default:   code = RED;
      endcase
    end else begin
      code = RED;
    end
    return code;
  endfunction

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Round-robin pick among four approach requests, scanning from the
// approach after the one served last (N,E,S,W order, wrapping).
module traffic_rr_arbiter
  import traffic_light_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_dir,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx_s;
  logic       hit_s;

  // First requester at offsets 1..4 from last_dir; offset 4 is last_dir itself.
  always_comb begin
    grant = 2'd0;
    valid = 1'b0;
    idx_s = 2'd0;
    hit_s = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx_s = last_dir + 2'(i);
      hit_s = !valid && req[idx_s];
      grant = hit_s ? idx_s : grant;
      valid = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/traffic_light.sv
// Four-way intersection controller: one approach at a time goes
// green -> yellow -> all-red, served round-robin among waiting approaches.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nss,
  input  logic       sns,
  input  logic       wes,
  input  logic       ews,
  output logic [1:0] n,
  output logic [1:0] s,
  output logic [1:0] w,
  output logic [1:0] e
);

  localparam int MAXC0 = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAXC  = (MAXC0 > ALLRED_CYCLES) ? MAXC0 : ALLRED_CYCLES;
  localparam int CW    = $clog2(MAXC) + 1;

  state_t        state_r, state_s;
  dir_t          cur_dir_r, cur_dir_s;
  dir_t          last_dir_r, last_dir_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    req_s;
  logic [1:0]    grant_s;
  logic          valid_s;
  logic          own_s;
  logic          others_s;

  // Request vector is indexed by direction encoding (bit0=N .. bit3=W).
  assign req_s    = {wes, sns, ews, nss};
  assign own_s    = req_s[cur_dir_r];
  assign others_s = |(req_s & ~(4'b0001 << cur_dir_r));

  traffic_rr_arbiter u_arb (
    .req      (req_s),
    .last_dir (last_dir_r),
    .grant    (grant_s),
    .valid    (valid_s)
  );

  // Next phase, served approach, last-served approach and phase counter.
  always_comb begin
    state_s    = state_r;
    cur_dir_s  = cur_dir_r;
    last_dir_s = last_dir_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CW{1'b0}};
        if (valid_s) begin
          state_s   = ST_GREEN;
          cur_dir_s = dir_t'(grant_s);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GREEN: begin
        if (cnt_r == CW'(GREEN_CYCLES - 1)) begin
          cnt_s = {CW{1'b0}};
          // Extend only when this approach is the sole one waiting.
          if (own_s && !others_s) begin
            state_s = ST_GREEN;
          end else begin
            state_s = ST_YELLOW;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_YELLOW: begin
        if (cnt_r == CW'(YELLOW_CYCLES - 1)) begin
          cnt_s      = {CW{1'b0}};
          state_s    = ST_ALLRED;
          last_dir_s = cur_dir_r;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_ALLRED: begin
        if (cnt_r == CW'(ALLRED_CYCLES - 1)) begin
          cnt_s = {CW{1'b0}};
          if (valid_s) begin
            state_s   = ST_GREEN;
            cur_dir_s = dir_t'(grant_s);
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State registers and lamps, the lamps decoded from next state so they change with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cur_dir_r  <= DIR_N;
      last_dir_r <= DIR_W;
      cnt_r      <= {CW{1'b0}};
      n          <= RED;
      s          <= RED;
      w          <= RED;
      e          <= RED;
    end else begin
      state_r    <= state_s;
      cur_dir_r  <= cur_dir_s;
      last_dir_r <= last_dir_s;
      cnt_r      <= cnt_s;
      n          <= lamp_code(state_s, cur_dir_s, DIR_N);
      s          <= lamp_code(state_s, cur_dir_s, DIR_S);
      w          <= lamp_code(state_s, cur_dir_s, DIR_W);
      e          <= lamp_code(state_s, cur_dir_s, DIR_E);
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: a timeline model predicts the lamp
// pattern after every edge, a monitor compares the DUT against it.
module tb_traffic_light;

  localparam int G = 8;
  localparam int Y = 2;
  localparam int A = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nss = 1'b0;
  logic       sns = 1'b0;
  logic       wes = 1'b0;
  logic       ews = 1'b0;
  logic [1:0] n, s, w, e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];

  // Model: phase 0=idle 1=green 2=yellow 3=allred; dir 0=N 1=E 2=S 3=W.
  int m_phase = 0;
  int m_dir   = 0;
  int m_last  = 3;
  int m_left  = 0;

  traffic_light #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .ALLRED_CYCLES (A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nss (nss),
    .sns (sns),
    .wes (wes),
    .ews (ews),
    .n   (n),
    .s   (s),
    .w   (w),
    .e   (e)
  );

  always #5 clk = ~clk;

  task automatic arbitrate(input logic [3:0] sens);
    m_phase = 0;
    for (int k = 1; k <= 4; k++) begin
      int d;
      d = (m_last + k) % 4;
      if (sens[d]) begin
        m_phase = 1;
        m_dir   = d;
        m_left  = G;
        break;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] sens);
    logic [7:0] lamps;
    if (!r) begin
      m_phase = 0;
      m_last  = 3;
    end else begin
      case (m_phase)
        0: arbitrate(sens);
        1: begin
          m_left--;
          if (m_left == 0) begin
            if (sens[m_dir] && (sens & ~(4'b0001 << m_dir)) == 4'b0000) m_left = G;
            else begin m_phase = 2; m_left = Y; end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin m_phase = 3; m_left = A; m_last = m_dir; end
        end
        default: begin
          m_left--;
          if (m_left == 0) arbitrate(sens);
        end
      endcase
    end
    lamps = 8'h00;
    if (m_phase == 1) lamps[2*m_dir +: 2] = 2'b10;
    if (m_phase == 2) lamps[2*m_dir +: 2] = 2'b01;
    exp_q.push_back(lamps);
  endtask

  // sens bit order follows direction index: [0]=N [1]=E [2]=S [3]=W.
  task automatic drive(input logic r, input logic [3:0] sens);
    @(negedge clk);
    rst = r;
    nss = sens[0];
    ews = sens[1];
    sns = sens[2];
    wes = sens[3];
    model_step(r, sens);
  endtask

  // Monitor: one expected lamp pattern per edge, compared just after it.
  initial begin
    logic [7:0] expv, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        got  = {w, s, e, n};
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL lamps cycle %0d: got n=%b e=%b s=%b w=%b, expected n=%b e=%b s=%b w=%b",
                   cyc, got[1:0], got[3:2], got[5:4], got[7:6],
                   expv[1:0], expv[3:2], expv[5:4], expv[7:6]);
        end
      end
    end
  end

  initial begin
    int guard;
    // Reset with every sensor waiting, then round-robin N,E,S,W,N...
    drive(1'b0, 4'hF);
    drive(1'b0, 4'hF);
    for (int i = 0; i < 50; i++) drive(1'b1, 4'hF);
    // Reset while east is yellow; service must restart from north.
    guard = 0;
    while (!(m_phase == 2 && m_dir == 1) && guard < 100) begin
      drive(1'b1, 4'hF);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL east-yellow not reached: waited %0d cycles, required < 100", guard);
    end
    drive(1'b0, 4'hF);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'hF);
    // Quiet intersection stays all red.
    for (int i = 0; i < 30; i++) drive(1'b1, 4'h0);
    // West alone, held long enough to extend green.
    for (int i = 0; i < 25; i++) drive(1'b1, 4'b1000);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h0);
    // North held; south arrives mid-green and ends the extension.
    for (int i = 0; i < 20; i++) drive(1'b1, 4'b0001);
    for (int i = 0; i < 30; i++) drive(1'b1, (i < 4) ? 4'b0101 : 4'b0100);
    // Random sensor traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] sv;
      logic       rv;
      sv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 199) != 0);
      drive(rv, sv);
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 4'h0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
